// File: rtl/imem_loader_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | imem_loader_pkg : shared state encoding and constants for imem_loader   |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package imem_loader_pkg;

  localparam logic [15:0] HALT_INSTR = 16'hF000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    LO   = 3'd2,
    WR   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK  = 3'd4,
`endif
    DONE = 3'd5
  } state_t;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_loader_ram.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | imem_ram : DEPTH x 16 instruction RAM, sync write, async read           |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module imem_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [15:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [15:0]   o_rdata
);

  // No reset: contents must survive a reset, including a partial load.
  logic [15:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : imem_ram
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | imem_loader : byte-stream program loader into instruction RAM; holds    |
// | the CPU while loading. Option macro: IMEM_LOADER_CHECKSUM_EN            |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic [AW-1:0] load_len,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] pc,
  output logic [15:0]   ir,
  output logic          cpu_hold,
  output logic          done,
  output logic [AW-1:0] wr_addr,
  output logic          err
);

  state_t        r_state;
  logic [AW-1:0] r_wr_addr;
  logic [AW-1:0] r_len;
  logic [7:0]    r_hi;
  logic [7:0]    r_lo;
  logic          r_in_ready;
  logic          r_cpu_hold;
  logic          r_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    r_sum;
  logic          r_err;
`endif

  logic          w_accept;
  logic          w_we;
  logic [AW-1:0] w_addr_inc;
  logic [15:0]   w_rdata;

  assign w_accept   = in_valid & r_in_ready;
  assign w_we       = (r_state == WR);
  assign w_addr_inc = r_wr_addr + 1'b1;

  // Outputs are registered alongside the state so they track it exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_wr_addr  <= '0;
      r_len      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_in_ready <= 1'b0;
      r_cpu_hold <= 1'b0;
      r_done     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum      <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load_start) begin
            r_cpu_hold <= 1'b1;
            r_wr_addr  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum      <= '0;
            r_err      <= 1'b0;
`endif
            if (load_len != '0) begin
              r_len      <= load_len;
              r_state    <= HI;
              r_in_ready <= 1'b1;
            end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              r_state    <= CHK;
              r_in_ready <= 1'b1;
`else
              r_state    <= DONE;
              r_done     <= 1'b1;
`endif
            end
          end
        end
        HI: begin
          if (w_accept) begin
            r_hi    <= in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum   <= r_sum + in_data;
`endif
            r_state <= LO;
          end
        end
        LO: begin
          if (w_accept) begin
            r_lo       <= in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum      <= r_sum + in_data;
`endif
            r_state    <= WR;
            r_in_ready <= 1'b0;
          end
        end
        WR: begin
          r_wr_addr <= w_addr_inc;
          if (w_addr_inc == r_len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_state    <= CHK;
            r_in_ready <= 1'b1;
`else
            r_state    <= DONE;
            r_done     <= 1'b1;
`endif
          end else begin
            r_state    <= HI;
            r_in_ready <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (w_accept) begin
            r_err      <= ((r_sum + in_data) != 8'd0);
            r_state    <= DONE;
            r_in_ready <= 1'b0;
            r_done     <= 1'b1;
          end
        end
`endif
        DONE: begin
          r_state    <= IDLE;
          r_cpu_hold <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b0;
          r_cpu_hold <= 1'b0;
        end
      endcase
    end
  end

  imem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_addr),
    .i_wdata ({r_hi, r_lo}),
    .i_raddr (pc),
    .o_rdata (w_rdata)
  );

  assign ir       = (r_state == IDLE) ? w_rdata : HALT_INSTR;
  assign in_ready = r_in_ready;
  assign cpu_hold = r_cpu_hold;
  assign done     = r_done;
  assign wr_addr  = r_wr_addr;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign err      = r_err;
`else
  assign err      = 1'b0;
`endif

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_imem_loader : directed self-checking bench for imem_loader           |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic [7:0]  load_len;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic        cpu_hold;
  logic        done;
  logic [7:0]  wr_addr;
  logic        err;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          start_cyc;
  int          lat;
  logic [7:0]  tb_sum;

  imem_loader #(.DEPTH(256), .AW(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_len   (load_len),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pc         (pc),
    .ir         (ir),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .wr_addr    (wr_addr),
    .err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic start_load(input logic [7:0] len);
    load_start = 1'b1;
    load_len   = len;
    tb_sum     = 8'h00;
    @(negedge clk);
    load_start = 1'b0;
    start_cyc  = cyc;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic ok;
    ok       = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      if (in_ready) ok = 1'b1;
      @(negedge clk);
    end
    if (ok) tb_sum = tb_sum + b;
    else check_eq("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(output int l);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      if (done) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) check_eq("done_timeout", 32'd0, 32'd1);
    l = cyc - start_cyc;
  endtask

  task automatic finish_load(output int l);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00 - tb_sum);
`endif
    in_valid = 1'b0;
    wait_done(l);
  endtask

  task automatic read_chk(input string tag, input logic [7:0] a, input logic [15:0] exp);
    pc = a;
    #1;
    check_eq(tag, {16'h0, ir}, {16'h0, exp});
  endtask

  initial begin
    reset = 1'b1; load_start = 1'b0; load_len = 8'h00;
    in_data = 8'h00; in_valid = 1'b0; pc = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_cpu_hold", cpu_hold, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_wr_addr", wr_addr, 0);
    check_eq("rst_err", err, 0);

    // Three words, no stalls
    start_load(8'd3);
    check_eq("t1_ir_halt", ir, 16'hF000);
    check_eq("t1_hold", cpu_hold, 1);
    send_byte(8'h20); send_byte(8'h00); send_byte(8'h20);
    send_byte(8'h11); send_byte(8'hD2); send_byte(8'h36);
    finish_load(lat);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check_eq("t1_done_lat", lat, 10);
`else
    check_eq("t1_done_lat", lat, 9);
`endif
    check_eq("t1_hold_at_done", cpu_hold, 1);
    @(negedge clk);
    check_eq("t1_done_pulse", done, 0);
    check_eq("t1_hold_fall", cpu_hold, 0);
    check_eq("t1_err", err, 0);
    read_chk("t1_mem0", 8'd0, 16'h2000);
    read_chk("t1_mem1", 8'd1, 16'h2011);
    read_chk("t1_mem2", 8'd2, 16'hD236);

    // Second load_start while in HI is ignored
    start_load(8'd2);
    load_start = 1'b1; load_len = 8'd1;
    send_byte(8'h12);
    load_start = 1'b0;
    send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    finish_load(lat);
`ifndef IMEM_LOADER_CHECKSUM_EN
    check_eq("t3_done_lat", lat, 6);
`endif
    @(negedge clk);
    check_eq("t3_wr_addr", wr_addr, 2);
    read_chk("t3_mem0", 8'd0, 16'h1234);
    read_chk("t3_mem1", 8'd1, 16'h5678);

    // Reset after the second of three words
    start_load(8'd3);
    send_byte(8'h20); send_byte(8'h00); send_byte(8'h20); send_byte(8'h11);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("t4_wr_addr_pre", wr_addr, 2);
    reset = 1'b1;
    #1;
    check_eq("t4_rst_wr_addr", wr_addr, 0);
    check_eq("t4_rst_hold", cpu_hold, 0);
    check_eq("t4_rst_in_ready", in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    read_chk("t4_mem0", 8'd0, 16'h2000);
    read_chk("t4_mem1", 8'd1, 16'h2011);
    read_chk("t4_mem2", 8'd2, 16'hD236);

    // Zero-length load writes nothing
    start_load(8'd0);
    finish_load(lat);
`ifndef IMEM_LOADER_CHECKSUM_EN
    check_eq("t5_done_lat", lat, 0);
`endif
    @(negedge clk);
    check_eq("t5_done_pulse", done, 0);
    @(negedge clk);
    check_eq("t5_hold", cpu_hold, 0);
    read_chk("t5_mem0", 8'd0, 16'h2000);

    // 255 words: wr_addr ends at 255 without wrapping
    start_load(8'd255);
    for (int i = 0; i < 255; i++) begin
      send_byte(8'(i));
      send_byte(~8'(i));
    end
    finish_load(lat);
    @(negedge clk);
    check_eq("t6_wr_addr", wr_addr, 255);
    read_chk("t6_mem0", 8'd0, 16'h00FF);
    read_chk("t6_mem2", 8'd2, 16'h02FD);
    read_chk("t6_mem254", 8'd254, 16'hFE01);

    // Stall between bytes 3 and 4
    start_load(8'd3);
    send_byte(8'h20); send_byte(8'h00); send_byte(8'h20);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("t2_stall_ready", in_ready, 1);
      @(negedge clk);
    end
    send_byte(8'h11); send_byte(8'hD2); send_byte(8'h36);
    finish_load(lat);
    @(negedge clk);
    read_chk("t2_mem0", 8'd0, 16'h2000);
    read_chk("t2_mem1", 8'd1, 16'h2011);
    read_chk("t2_mem2", 8'd2, 16'hD236);

`ifdef IMEM_LOADER_CHECKSUM_EN
    start_load(8'd1);
    send_byte(8'h20); send_byte(8'h00); send_byte(8'hE0);
    in_valid = 1'b0;
    wait_done(lat);
    @(negedge clk);
    check_eq("t7_err_good", err, 0);
    start_load(8'd1);
    send_byte(8'h20); send_byte(8'h00); send_byte(8'hE1);
    in_valid = 1'b0;
    wait_done(lat);
    @(negedge clk);
    check_eq("t7_err_bad", err, 1);
    start_load(8'd1);
    check_eq("t7_err_clear", err, 0);
    send_byte(8'h20); send_byte(8'h00);
    finish_load(lat);
    @(negedge clk);
`else
    check_eq("t7_err_tied", err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_imem_loader
`default_nettype wire
